// File: rtl/rca_pkg.sv
// Shared constants for the 32-bit ripple-carry adder and its benches.
package rca_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/ripple_carry_adder_32_if.sv
// Operand/result bundle for ripple_carry_adder_32.
// With RCA_OVF_STICKY_EN defined, it also carries ovf_clr and ovf_sticky.
interface ripple_carry_adder_32_if #(
  parameter int unsigned WIDTH = rca_pkg::WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

`ifdef RCA_OVF_STICKY_EN
  logic             ovf_clr;
  logic             ovf_sticky;

  modport master (
    output in_valid, a, b, cin, ovf_clr,
    input  sum, cout, overflow, out_valid, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, cin, ovf_clr,
    output sum, cout, overflow, out_valid, ovf_sticky
  );
`else
  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, out_valid
  );
`endif

endinterface

// File: rtl/ripple_carry_adder_32_full_adder_cell.sv
// Single full-adder cell: one bit of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/ripple_carry_adder_32.sv
// Signed ripple-carry adder with a registered output stage (1-cycle latency).
// Optional sticky overflow flag is enabled by RCA_OVF_STICKY_EN.
module ripple_carry_adder_32 #(
  parameter int unsigned WIDTH = rca_pkg::WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  ripple_carry_adder_32_if.slave bus
);

  import rca_pkg::*;

  logic [WIDTH-1:0] sum_core;
  logic             cout_core;
  logic             ovf_core;

  // Each stage keeps its own carry so the chain is not one self-feeding vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = bus.cin;
    end else begin : g_rest
      assign ci = g_cell[i-1].co;
    end

    full_adder_cell u_cell (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (ci),
      .s  (sum_core[i]),
      .co (co)
    );
  end

  assign cout_core = g_cell[WIDTH-1].co;
  assign ovf_core  = g_cell[WIDTH-1].co ^ g_cell[WIDTH-1].ci;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = sum_core;
      cout_d = cout_core;
      ovf_d  = ovf_core;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = valid_q;

`ifdef RCA_OVF_STICKY_EN
  logic sticky_q, sticky_d;

  // Set has priority over clear when both land on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.ovf_clr) sticky_d = 1'b0;
    if (bus.in_valid && ovf_core) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign bus.ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_32.sv
// Directed self-checking bench for ripple_carry_adder_32.
module tb_ripple_carry_adder_32;

  import rca_pkg::*;

  logic clk;
  logic rst_n;

  ripple_carry_adder_32_if #(.WIDTH(WIDTH)) bus ();

  ripple_carry_adder_32 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, ".sum"}, bus.sum, v.sum);
    check({tag, ".cout"}, {31'd0, bus.cout}, {31'd0, v.cout});
    check({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, v.ovf});
    check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef RCA_OVF_STICKY_EN
    bus.ovf_clr = clr;
`endif
    @(posedge clk);
    #1;
`ifdef RCA_OVF_STICKY_EN
    bus.ovf_clr = 1'b0;
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".sum"}, bus.sum, 32'd0);
    check({tag, ".cout"}, {31'd0, bus.cout}, 32'd0);
    check({tag, ".ovf"}, {31'd0, bus.overflow}, 32'd0);
    check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{SIGNED_MAX, 32'sd1, 1'b0, SIGNED_MIN, 1'b0, 1'b1};
    vecs[1] = '{SIGNED_MIN, -32'sd1, 1'b0, SIGNED_MAX, 1'b1, 1'b1};
    vecs[2] = '{32'sd52, -32'sd31, 1'b0, 32'sd21, 1'b1, 1'b0};
    vecs[3] = '{32'sd152, 32'sd2539, 1'b0, 32'sd2691, 1'b0, 1'b0};
    vecs[4] = '{-32'sd495955, -32'sd4548, 1'b0, -32'sd500503, 1'b1, 1'b0};
    vecs[5] = '{-32'sd451, 32'sd4498, 1'b0, 32'sd4047, 1'b1, 1'b0};
    vecs[6] = '{32'sd4561, -32'sd89, 1'b0, 32'sd4472, 1'b1, 1'b0};
    vecs[7] = '{32'sd0, 32'sd0, 1'b0, 32'sd0, 1'b0, 1'b0};
    vecs[8] = '{-32'sd1, 32'sd0, 1'b1, 32'sd0, 1'b1, 1'b0};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
`ifdef RCA_OVF_STICKY_EN
    bus.ovf_clr  = 1'b0;
`endif
    #3;
    check_zero("reset");
`ifdef RCA_OVF_STICKY_EN
    check("reset.sticky", {31'd0, bus.ovf_sticky}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i]);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Result must hold while in_valid is low.
    apply(vecs[3]);
    idle(1'b0);
    check("hold.sum", bus.sum, 32'd2691);
    check("hold.valid", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset in the middle of a valid stream.
    apply(vecs[0]);
    check_vec("pre_rst", vecs[0]);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    apply(vecs[5]);
    check_vec("post_rst", vecs[5]);

`ifdef RCA_OVF_STICKY_EN
    check("sticky.after_rst", {31'd0, bus.ovf_sticky}, 32'd0);
    apply(vecs[0]);
    check("sticky.set", {31'd0, bus.ovf_sticky}, 32'd1);
    apply(vecs[2]);
    check("sticky.keep", {31'd0, bus.ovf_sticky}, 32'd1);
    idle(1'b1);
    check("sticky.clr", {31'd0, bus.ovf_sticky}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = vecs[1].a;
    bus.b        = vecs[1].b;
    bus.cin      = vecs[1].cin;
    bus.ovf_clr  = 1'b1;
    @(posedge clk);
    #1;
    bus.ovf_clr  = 1'b0;
    check("sticky.set_wins", {31'd0, bus.ovf_sticky}, 32'd1);
`endif

    idle(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder_32.md
Name: ripple_carry_adder_32

Overview:
Signed two's-complement ripple-carry adder with carry-in, carry-out and signed-overflow detection. The adder core is a combinational chain of WIDTH full-adder cells. Its results are captured in an output register stage, giving one cycle of latency. The block is the integer add datapath primitive for the ALU/arith cluster.

Parameters:
WIDTH, 32, operand and sum width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle; result captured on this edge
a  input  WIDTH  signed operand A (two's complement)
b  input  WIDTH  signed operand B (two's complement)
cin  input  1  carry-in, weight 1
sum  output  WIDTH  registered signed result, a+b+cin modulo 2^WIDTH
cout  output  1  registered carry-out of the MSB cell (unsigned carry)
overflow  output  1  registered signed overflow flag
out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, sum=0, cout=0, overflow=0 and out_valid=0 immediately, independent of clk.
- Core: c[0]=cin. Cell i: s[i]=a[i]^b[i]^c[i]; c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]). cout=c[WIDTH].
- Overflow: overflow = c[WIDTH] ^ c[WIDTH-1]. Equivalently, the operand signs are equal and the sum sign differs.
- Arithmetic wraps modulo 2^WIDTH; no saturation.
- Latency: 1 cycle. On a clk rising edge with in_valid=1, sum, cout and overflow load the core results and out_valid goes to 1.
- On an edge with in_valid=0: out_valid goes to 0, and sum, cout and overflow hold their previous values.
- Back-to-back in_valid: one result per cycle, no stalls, no backpressure.
- Reset asserted mid-operation: the pending result is discarded.
- After reset release, the first edge with in_valid=1 produces a valid result on the following cycle.
- The core contains no lookahead or carry-select logic; the carry strictly ripples through the cells.

Optional Feature:
Macro RCA_OVF_STICKY_EN.
- Defined: adds input ovf_clr (1 bit) and output ovf_sticky (1 bit).
  - ovf_sticky is reset to 0.
  - It is set on any edge that loads overflow=1.
  - It is cleared on an edge with ovf_clr=1.
  - If set and clear occur on the same edge, set wins.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package rca_pkg: default WIDTH constant (32), plus constants SIGNED_MAX (2^(WIDTH-1)-1) and SIGNED_MIN (-2^(WIDTH-1)) for use by benches.
- One sub-module, full_adder_cell: inputs a, b, ci; outputs s, co.
- The top level instantiates WIDTH cells in a generate loop and adds the output registers.

Test Plan:
- a=2147483647, b=1, cin=0, in_valid=1 -> next cycle: sum=-2147483648, overflow=1, cout=0, out_valid=1.
- a=-2147483648, b=-1, cin=0 -> sum=2147483647, overflow=1, cout=1.
- Mixed-sign and same-sign non-overflow cases, all with overflow=0:
  - 52+(-31) -> 21, cout=1
  - 152+2539 -> 2691
  - -495955+(-4548) -> -500503
  - -451+4498 -> 4047
  - 4561+(-89) -> 4472
- 0+0 with cin=0 -> sum=0, overflow=0, cout=0. Then a=-1, b=0, cin=1 -> sum=0, cout=1, overflow=0 (full carry ripple).
- Assert rst_n low mid-stream with in_valid=1 -> all outputs 0 immediately. Drop in_valid for one cycle -> out_valid=0 and sum held.
- With RCA_OVF_STICKY_EN: run the overflow case then a non-overflow case -> ovf_sticky stays 1. Then pulse ovf_clr -> ovf_sticky=0. Overflow and ovf_clr on the same edge -> ovf_sticky=1.
